// File: rtl/mem_access_unit_if.sv
// Data-memory port bundle between the MEM-stage access unit and the data memory.
interface mem_access_unit_if #(
    parameter int DATA_BITS = 32
);
    logic                 dmem_req;
    logic                 dmem_we;
    logic [DATA_BITS-1:0] dmem_addr;
    logic [3:0]           dmem_be;
    logic [DATA_BITS-1:0] dmem_wdata;
    logic                 dmem_ack;
    logic [DATA_BITS-1:0] dmem_rdata;

    // Access unit drives the request side and receives completion.
    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    // Memory side.
    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory master: issues one req/ack transaction per load/store,
// holds the pipeline while it is outstanding, and returns size/sign-extended load data.
module mem_access_unit #(
    parameter int DATA_BITS      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 acc_valid,
    input  logic                 MemToReg,
    input  logic                 MemWrite,
    input  logic                 Sb,
    input  logic                 Sh,
    input  logic [1:0]           ExtrWord,
    input  logic                 ExtrSigned,
    input  logic [DATA_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] store_data,
    mem_access_unit_if.master    dmem,
    output logic                 mem_busy,
    output logic [DATA_BITS-1:0] load_data,
    output logic                 load_valid,
    output logic                 addr_err,
    output logic                 bus_err
);

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    // Counter value seen in the last REQ cycle allowed before abort.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

    state_t               state_q, state_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [DATA_BITS-1:0] addr_q, addr_d;
    logic [3:0]           be_q, be_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [1:0]           size_q, size_d;
    logic                 sign_q, sign_d;
    logic [1:0]           lane_q, lane_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [DATA_BITS-1:0] load_data_q, load_data_d;
    logic                 load_valid_q, load_valid_d;
    logic                 addr_err_q, addr_err_d;
    logic                 bus_err_q, bus_err_d;

    logic                 access;
    logic [1:0]           size_in;
    logic                 misaligned;
    logic [3:0]           be_in;
    logic [DATA_BITS-1:0] wdata_in;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [DATA_BITS-1:0] ext_data;

    // Decode the EX/MEM control bundle: size, alignment, lanes and replicated write data.
    always_comb begin
        access   = acc_valid & (MemToReg | MemWrite);
        size_in  = ExtrWord;
        be_in    = 4'b1111;
        wdata_in = '0;
        if (MemWrite) begin
            // Store wins when both load and store flags are set.
            if (Sb) begin
                size_in  = SZ_BYTE;
                be_in    = 4'b0001 << addr[1:0];
                wdata_in = {4{store_data[7:0]}};
            end else if (Sh) begin
                size_in  = SZ_HALF;
                be_in    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{store_data[15:0]}};
            end else begin
                size_in  = SZ_WORD;
                be_in    = 4'b1111;
                wdata_in = store_data;
            end
        end
        // Encoding 11 behaves as a word access.
        misaligned = ((size_in == SZ_HALF) && addr[0]) ||
                     ((size_in != SZ_BYTE) && (size_in != SZ_HALF) && (addr[1:0] != 2'b00));
    end

    // Pick the addressed lane of the returned word and extend it.
    always_comb begin
        byte_sel = dmem.dmem_rdata[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (size_q)
            SZ_BYTE: ext_data = {{(DATA_BITS-8){sign_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: ext_data = {{(DATA_BITS-16){sign_q & half_sel[15]}}, half_sel};
            default: ext_data = dmem.dmem_rdata;
        endcase
    end

    // Next-state and datapath updates; pulses default low, everything else holds.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        sign_d       = sign_q;
        lane_d       = lane_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        addr_err_d   = 1'b0;
        bus_err_d    = 1'b0;
        mem_busy     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        addr_err_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        mem_busy = 1'b1;
                        req_d    = 1'b1;
                        we_d     = MemWrite;
                        addr_d   = {addr[DATA_BITS-1:2], 2'b00};
                        be_d     = be_in;
                        wdata_d  = wdata_in;
                        size_d   = size_in;
                        sign_d   = ExtrSigned;
                        lane_d   = addr[1:0];
                        cnt_d    = '0;
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                mem_busy = 1'b1;
                if (dmem.dmem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        load_data_d  = ext_data;
                        load_valid_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                // Inputs still show the retiring instruction here, so they are ignored.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Bus, counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            size_q       <= SZ_WORD;
            sign_q       <= 1'b0;
            lane_q       <= 2'b00;
            cnt_q        <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            lane_q       <= lane_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            addr_err_q   <= addr_err_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign load_data       = load_data_q;
    assign load_valid      = load_valid_q;
    assign addr_err        = addr_err_q;
    assign bus_err         = bus_err_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage data-memory master sitting directly behind the EX/MEM pipeline register. It consumes the registered memory-control bundle (MemToReg, MemWrite, Sb, Sh, ExtrWord, ExtrSigned) plus address (result_1_out) and store data (regfile_out2_out). It runs a req/ack transaction on the data-memory port and returns extended load data toward MEM/WB. It asserts a hold request while a transaction is outstanding, so the pipeline registers stop latching.

Parameters:
DATA_BITS, 32, data/address width (fixed 32; byte lanes assume 4)
TIMEOUT_CYCLES, 255, max cycles waiting for dmem_ack before abort (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
acc_valid  in  1  EX/MEM slot holds a real instruction
MemToReg  in  1  load access
MemWrite  in  1  store access
Sb  in  1  store byte
Sh  in  1  store halfword (Sb=Sh=0 => word)
ExtrWord  in  2  load size: 00 word, 01 byte, 10 halfword, 11 treated as word
ExtrSigned  in  1  1 sign-extend, 0 zero-extend
addr  in  DATA_BITS  byte address (result_1_out)
store_data  in  DATA_BITS  store source (regfile_out2_out)
dmem_req  out  1  transaction request
dmem_we  out  1  1 write, 0 read
dmem_addr  out  DATA_BITS  word address {addr[31:2],2'b00}
dmem_be  out  4  byte enables, bit i = byte lane i (little-endian)
dmem_wdata  out  DATA_BITS  lane-replicated write data
dmem_ack  in  1  memory completion, sampled only in REQ
dmem_rdata  in  DATA_BITS  read word, valid with dmem_ack
mem_busy  out  1  pipeline hold request (combinational)
load_data  out  DATA_BITS  extended load result (registered)
load_valid  out  1  one-cycle pulse, load_data updated
addr_err  out  1  one-cycle pulse, misaligned access
bus_err  out  1  one-cycle pulse, timeout abort

Behaviour:
- Reset: state IDLE; dmem_req, dmem_we, dmem_be, load_valid, addr_err, bus_err = 0; dmem_addr, dmem_wdata, load_data = 0; timeout counter = 0. Reset mid-transaction drops dmem_req at the same edge. Any later ack is ignored because state is IDLE.
- Access = acc_valid & (MemToReg | MemWrite). When both MemToReg and MemWrite are set, MemWrite wins and the access is a store.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. Size comes from Sb/Sh for stores and ExtrWord for loads. In IDLE the block issues no request, pulses addr_err the next cycle, and goes to DONE. load_data is unchanged.
- States: IDLE, REQ, DONE.
- IDLE: on an aligned access, latch addr/be/wdata/we/size/sign, set dmem_req=1 at the edge, go REQ. mem_busy=1 combinationally in this cycle.
- REQ: mem_busy=1. dmem_* outputs are held stable. Counter increments each cycle.
  - dmem_ack=1: drop dmem_req. For a read, load_data <= extended rdata and load_valid <= 1. Go DONE.
  - Counter reaches TIMEOUT_CYCLES with no ack: drop dmem_req, bus_err <= 1, go DONE.
- DONE: mem_busy=0. Inputs are ignored, because they still show the same instruction until the pipeline advances at this edge. Pulses clear. Go IDLE.
- Latency: an aligned access with same-cycle-as-REQ ack has mem_busy high for 2 cycles, and load_valid appears in the 3rd cycle (DONE).
- Byte enables and write data:
  - sb: be = 1<<addr[1:0], wdata = {4{byte}}.
  - sh: be = addr[1] ? 1100 : 0011, wdata = {2{half}}.
  - sw: be = 1111.
  - Loads: be = 1111, we = 0.
- Load extraction:
  - Byte lane = addr[1:0].
  - Halfword lane = addr[1].
  - Extension per ExtrSigned to DATA_BITS.
- Non-access cycle (acc_valid=0 or neither MemToReg nor MemWrite): stay in IDLE, mem_busy=0, nothing issued.

Test Plan:
- Load word: addr=0x100, rdata=0xDEADBEEF, ack 1 cycle after req -> dmem_addr=0x100, be=1111, we=0; load_valid pulse with load_data=0xDEADBEEF; mem_busy high exactly while in IDLE-issue + REQ.
- Signed byte load: ExtrWord=01, ExtrSigned=1, addr=0x103, rdata=0x80112233 -> load_data=0xFFFFFF80. Repeat with ExtrSigned=0 -> 0x00000080.
- Store half: Sh=1, addr=0x202, store_data=0x1234ABCD -> dmem_addr=0x200, be=1100, wdata=0xABCDABCD, we=1; load_data unchanged, no load_valid.
- Misaligned word load: addr=0x101 -> no dmem_req; addr_err one-cycle pulse; mem_busy stays 0.
- Timeout: TIMEOUT_CYCLES=4, ack never asserted -> dmem_req drops after 4 REQ cycles; bus_err pulses once; state returns to IDLE.
- Reset during REQ: assert rst while dmem_req=1, then ack arrives -> dmem_req=0 at the reset edge; ack ignored; load_valid stays 0.
